ahb_dma_regs: RTL and testbench
===============================

# ahb_dma_regs

Multi-channel AHB-Lite slave register file for the DMA engine. It generalises the single-channel DMA register slave to NUM_CH channels with parameterised count and burst-size widths. It adds a W1C interrupt status register, a combined irq output, and a two-cycle AHB ERROR response for illegal accesses. It sits between the AHB interconnect and the DMA channel engines.

## Interface
- NUM_CH, 4, number of channels, 1..8
- CNT_W, 16, block_count width, 1..16
- BS_W, 5, block_size width in words, 1..11
- hclk  in  1  AHB clock, all state on rising edge
- hreset  in  1  reset, asynchronous, active-high
- hsel, hwrite, hready_in  in  1  AHB slave select, direction, bus ready
- haddr  in  8  byte address offset
- htrans  in  2  AHB transfer type
- hsize  in  3  transfer size
- hwdata  in  32  write data
- hrdata  out  32  read data
- hready_out  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- start, dma_en  out  NUM_CH  per-channel start pulse, enable
- src_addr, dst_addr  out  NUM_CH*32  channel c at bits [32c+31:32c]
- block_count  out  NUM_CH*CNT_W  remaining blocks
- block_size  out  NUM_CH*BS_W  words per block
- rd_update, wr_update, done_set  in  NUM_CH  engine events, one-cycle pulses
- irq  out  1  OR of (int_status & int_enable)

## Operation
- Address phase is accepted when hsel & hready_in & htrans[1]. Address, hwrite, and legality are registered for the data phase.
- Map:
  - haddr[7]=0: channel haddr[6:4], register haddr[3:2]
    - 0 CTRL: bit0 start (write-only pulse, reads 0), bit1 dma_en
    - 1 SRC
    - 2 DST
    - 3 CNT: {block_size, block_count}, packed at bit 16 up
  - 0x80 INT_STATUS: W1C, NUM_CH bits
  - 0x84 INT_ENABLE: RW
- Illegal accesses are ERROR and have no side effects:
  - channel index ≥ NUM_CH
  - haddr[7]=1 with haddr[6:3]≠0
  - hsize≠3'b010
  - haddr[1:0]≠0
- Write data phase: the selected register is loaded from hwdata. Unused bits are ignored and read back as 0.
- Writing CTRL bit0=1 asserts start[c] for exactly one cycle.
- rd_update[c]: src_addr += block_size<<2 (mod 2^32). block_count -= 1, holding at 0.
- wr_update[c]: dst_addr += block_size<<2 (mod 2^32).
- done_set[c] sets int_status[c].
- Simultaneous events:
  - AHB write and update to the same register in the same cycle: the AHB write wins and the update is dropped.
  - done_set and W1C clear of the same bit in the same cycle: set wins.
- Error FSM:
  - OKAY → ERR1 on an illegal accepted address phase.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → OKAY, or ERR1 if another illegal transfer is accepted.
- Reset values: all registers and outputs are 0, except hready_out=1 and hresp=00. A reset mid-transfer aborts the transfer, returns the FSM to OKAY, and clears every start pulse.

## Timing
- Zero wait states for legal transfers; hready_out stays 1.
- hrdata is registered. It is valid during the data phase (the cycle after address acceptance) and is 0 at all other times and for writes.
- Register update takes effect at the clock edge ending the data phase. A read in the next data phase returns the new value.
- start[c] is high in the cycle after the CTRL write data phase.
- ERR1: hready_out=0, hresp=01. ERR2: hready_out=1, hresp=01.
- Update and done_set inputs take effect on the next edge. irq is registered, so it follows int_status by 1 cycle.

## Structure
- Package ahb_dma_pkg holds:
  - register offsets (CTRL, SRC, DST, CNT, INT_STATUS, INT_ENABLE)
  - HTRANS and HRESP encodings
  - error FSM state enum
- Sub-module ahb_dma_ch_regs is instantiated NUM_CH times. It holds one channel's CTRL/SRC/DST/CNT registers, the update arithmetic, and start pulse generation.
- The top level holds AHB decode, the error FSM, the read mux, and interrupt logic.

## Test plan
- Write SRC ch2=0x1000_0000, block_size=4, block_count=3, then pulse rd_update[2] four times → src_addr ch2=0x1000_0040, block_count=0 (holds at 0 on the fourth pulse).
- Write CTRL ch1=0x3 → start[1] high for exactly 1 cycle, dma_en[1]=1, readback=0x2.
- NUM_CH=4, read haddr=0x50 → ERR1 then ERR2 (hready_out 0 then 1, hresp=01), no state change. Follow with a legal read, which returns OKAY data.
- done_set[0] with INT_ENABLE=0x1 → irq=1. Write INT_STATUS=0x1 in the same cycle as a new done_set[0] → bit stays 1.
- AHB write DST ch0=0x2000 coinciding with wr_update[0] → dst_addr=0x2000.
- Assert hreset during ERR1 → hready_out=1, hresp=00, all outputs 0.

Source files
------------

// File: rtl/ahb_dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : ahb_dma_pkg                                               |
// | Purpose  : Shared constants and types for the DMA AHB register slave |
// | Revision : 1.0  initial multi-channel release                        |
// +----------------------------------------------------------------------+
package ahb_dma_pkg;

  // Per-channel register index (haddr[3:2])
  localparam logic [1:0] c_reg_ctrl = 2'd0;
  localparam logic [1:0] c_reg_src  = 2'd1;
  localparam logic [1:0] c_reg_dst  = 2'd2;
  localparam logic [1:0] c_reg_cnt  = 2'd3;

  // Global interrupt registers
  localparam logic [7:0] c_addr_int_status = 8'h80;
  localparam logic [7:0] c_addr_int_enable = 8'h84;

  // AHB transfer types
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  // AHB responses
  localparam logic [1:0] c_hresp_okay  = 2'b00;
  localparam logic [1:0] c_hresp_error = 2'b01;

  // Only 32-bit accesses are supported
  localparam logic [2:0] c_hsize_word = 3'b010;

  // Two-cycle ERROR response sequencer
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_dma_ch_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ahb_dma_ch_regs                                           |
// | Purpose  : One DMA channel: CTRL/SRC/DST/CNT registers, address and  |
// |            count update arithmetic, start pulse generation           |
// | Revision : 1.0  initial multi-channel release                        |
// +----------------------------------------------------------------------+
module ahb_dma_ch_regs
  import ahb_dma_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int BS_W  = 5
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             wr_en,
  input  logic [1:0]       wr_reg,
  input  logic [31:0]      wdata,
  input  logic [1:0]       rd_reg,
  input  logic             rd_update,
  input  logic             wr_update,
  output logic             start,
  output logic             dma_en,
  output logic [31:0]      src_addr,
  output logic [31:0]      dst_addr,
  output logic [CNT_W-1:0] block_count,
  output logic [BS_W-1:0]  block_size,
  output logic [31:0]      rdata_nxt
);

  logic             r_start;
  logic             r_en;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [CNT_W-1:0] r_cnt;
  logic [BS_W-1:0]  r_bs;

  logic             w_start_nxt;
  logic             w_en_nxt;
  logic [31:0]      w_src_nxt;
  logic [31:0]      w_dst_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [BS_W-1:0]  w_bs_nxt;
  logic [31:0]      w_step;
  logic             w_unused_wdata;

  // Byte stride of one block (block_size words)
  assign w_step = {{(30-BS_W){1'b0}}, r_bs, 2'b00};

  // Bits above the packed fields are intentionally ignored on writes
  assign w_unused_wdata = &{1'b0, wdata};

  // Next-state: an AHB write to a register overrides any engine update to it
  always_comb begin
    w_start_nxt = wr_en && (wr_reg == c_reg_ctrl) && wdata[0];
    w_en_nxt    = r_en;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_cnt_nxt   = r_cnt;
    w_bs_nxt    = r_bs;
    if (wr_en && (wr_reg == c_reg_ctrl)) w_en_nxt = wdata[1];
    if (wr_en && (wr_reg == c_reg_src))  w_src_nxt = wdata;
    else if (rd_update)                  w_src_nxt = r_src + w_step;
    if (wr_en && (wr_reg == c_reg_dst))  w_dst_nxt = wdata;
    else if (wr_update)                  w_dst_nxt = r_dst + w_step;
    if (wr_en && (wr_reg == c_reg_cnt)) begin
      w_cnt_nxt = wdata[CNT_W-1:0];
      w_bs_nxt  = wdata[16 +: BS_W];
    end else if (rd_update && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Read view of the post-edge contents, so a read right after a write sees it
  always_comb begin
    rdata_nxt = '0;
    case (rd_reg)
      c_reg_ctrl: rdata_nxt[1] = w_en_nxt;
      c_reg_src:  rdata_nxt    = w_src_nxt;
      c_reg_dst:  rdata_nxt    = w_dst_nxt;
      default: begin
        rdata_nxt[CNT_W-1:0]  = w_cnt_nxt;
        rdata_nxt[16 +: BS_W] = w_bs_nxt;
      end
    endcase
  end

  // Channel state registers
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_start <= 1'b0;
      r_en    <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_bs    <= '0;
    end else begin
      r_start <= w_start_nxt;
      r_en    <= w_en_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bs    <= w_bs_nxt;
    end
  end

  assign start       = r_start;
  assign dma_en      = r_en;
  assign src_addr    = r_src;
  assign dst_addr    = r_dst;
  assign block_count = r_cnt;
  assign block_size  = r_bs;

endmodule
`default_nettype wire

// File: rtl/ahb_dma_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ahb_dma_regs                                              |
// | Purpose  : Multi-channel DMA AHB-Lite register slave: decode, ERROR  |
// |            response sequencing, read mux and interrupt logic         |
// | Revision : 1.0  initial multi-channel release                        |
// +----------------------------------------------------------------------+
module ahb_dma_regs
  import ahb_dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int BS_W   = 5
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic                    hwrite,
  input  logic                    hready_in,
  input  logic [7:0]              haddr,
  input  logic [1:0]              htrans,
  input  logic [2:0]              hsize,
  input  logic [31:0]             hwdata,
  output logic [31:0]             hrdata,
  output logic                    hready_out,
  output logic [1:0]              hresp,
  output logic [NUM_CH-1:0]       start,
  output logic [NUM_CH-1:0]       dma_en,
  output logic [NUM_CH*32-1:0]    src_addr,
  output logic [NUM_CH*32-1:0]    dst_addr,
  output logic [NUM_CH*CNT_W-1:0] block_count,
  output logic [NUM_CH*BS_W-1:0]  block_size,
  input  logic [NUM_CH-1:0]       rd_update,
  input  logic [NUM_CH-1:0]       wr_update,
  input  logic [NUM_CH-1:0]       done_set,
  output logic                    irq
);

  logic              w_accept;
  logic              w_ch_ok;
  logic              w_legal;
  logic              r_dp_wr;
  logic [7:0]        r_dp_addr;
  err_state_t        r_err_state;
  err_state_t        w_err_nxt;
  logic [NUM_CH-1:0] w_ch_wr;
  logic [31:0]       w_ch_rdata [NUM_CH];
  logic              w_int_st_wr;
  logic              w_int_en_wr;
  logic [NUM_CH-1:0] r_int_status;
  logic [NUM_CH-1:0] r_int_enable;
  logic [NUM_CH-1:0] w_int_status_nxt;
  logic [NUM_CH-1:0] w_int_enable_nxt;
  logic [31:0]       w_rd_word;
  logic [31:0]       r_hrdata;
  logic              r_irq;

  // Address-phase acceptance and legality decode
  assign w_accept = hsel && hready_in &&
                    ((htrans == c_htrans_nonseq) || (htrans == c_htrans_seq));
  assign w_ch_ok  = ({1'b0, haddr[6:4]} < 4'(NUM_CH));
  assign w_legal  = (hsize == c_hsize_word) && (haddr[1:0] == 2'b00) &&
                    (haddr[7] ? (haddr[6:3] == 4'b0000) : w_ch_ok);

  // Data-phase write context; illegal transfers never reach a data phase
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_dp_wr   <= 1'b0;
      r_dp_addr <= '0;
    end else begin
      r_dp_wr   <= w_accept && w_legal && hwrite;
      r_dp_addr <= haddr;
    end
  end

  assign w_int_st_wr = r_dp_wr && (r_dp_addr == c_addr_int_status);
  assign w_int_en_wr = r_dp_wr && (r_dp_addr == c_addr_int_enable);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ch_wr[c] = r_dp_wr && !r_dp_addr[7] && (r_dp_addr[6:4] == 3'(c));

    ahb_dma_ch_regs #(
      .CNT_W (CNT_W),
      .BS_W  (BS_W)
    ) u_ch (
      .hclk        (hclk),
      .hreset      (hreset),
      .wr_en       (w_ch_wr[c]),
      .wr_reg      (r_dp_addr[3:2]),
      .wdata       (hwdata),
      .rd_reg      (haddr[3:2]),
      .rd_update   (rd_update[c]),
      .wr_update   (wr_update[c]),
      .start       (start[c]),
      .dma_en      (dma_en[c]),
      .src_addr    (src_addr[32*c +: 32]),
      .dst_addr    (dst_addr[32*c +: 32]),
      .block_count (block_count[CNT_W*c +: CNT_W]),
      .block_size  (block_size[BS_W*c +: BS_W]),
      .rdata_nxt   (w_ch_rdata[c])
    );
  end

  // Interrupt next-state: a done_set in the same cycle beats the W1C clear
  always_comb begin
    w_int_status_nxt = (r_int_status & ~(w_int_st_wr ? hwdata[NUM_CH-1:0] : '0)) | done_set;
    w_int_enable_nxt = w_int_en_wr ? hwdata[NUM_CH-1:0] : r_int_enable;
  end

  // Interrupt registers and registered irq
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_int_status <= '0;
      r_int_enable <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_int_status <= w_int_status_nxt;
      r_int_enable <= w_int_enable_nxt;
      r_irq        <= |(r_int_status & r_int_enable);
    end
  end

  // Read mux over the post-edge register view, selected by the address phase
  always_comb begin
    w_rd_word = '0;
    if (haddr[7]) begin
      if (haddr[2]) w_rd_word[NUM_CH-1:0] = w_int_enable_nxt;
      else          w_rd_word[NUM_CH-1:0] = w_int_status_nxt;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (haddr[6:4] == 3'(c)) w_rd_word = w_ch_rdata[c];
      end
    end
  end

  // Registered read data: non-zero only in a legal read data phase
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_hrdata <= '0;
    else        r_hrdata <= (w_accept && w_legal && !hwrite) ? w_rd_word : '0;
  end

  // Error sequencer state register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_err_state <= ST_OKAY;
    else        r_err_state <= w_err_nxt;
  end

  // Error sequencer next state and response outputs
  always_comb begin
    w_err_nxt  = r_err_state;
    hready_out = 1'b1;
    hresp      = c_hresp_okay;
    case (r_err_state)
      ST_OKAY: begin
        if (w_accept && !w_legal) w_err_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp      = c_hresp_error;
        w_err_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = c_hresp_error;
        w_err_nxt = (w_accept && !w_legal) ? ST_ERR1 : ST_OKAY;
      end
      default: w_err_nxt = ST_OKAY;
    endcase
  end

  assign hrdata = r_hrdata;
  assign irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ahb_dma_regs                                           |
// | Purpose  : Self-checking bench for ahb_dma_regs with a behavioural   |
// |            register-map model, directed scenarios and random traffic |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ahb_dma_regs;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int BS_W   = 5;

  logic                    hclk = 1'b0;
  logic                    hreset;
  logic                    hsel, hwrite, hready_in;
  logic [7:0]              haddr;
  logic [1:0]              htrans;
  logic [2:0]              hsize;
  logic [31:0]             hwdata;
  logic [31:0]             hrdata;
  logic                    hready_out;
  logic [1:0]              hresp;
  logic [NUM_CH-1:0]       start, dma_en;
  logic [NUM_CH*32-1:0]    src_addr, dst_addr;
  logic [NUM_CH*CNT_W-1:0] block_count;
  logic [NUM_CH*BS_W-1:0]  block_size;
  logic [NUM_CH-1:0]       rd_update, wr_update, done_set;
  logic                    irq;

  always #5 hclk = ~hclk;

  ahb_dma_regs #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BS_W(BS_W)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hwrite(hwrite),
    .hready_in(hready_in), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp),
    .start(start), .dma_en(dma_en), .src_addr(src_addr), .dst_addr(dst_addr),
    .block_count(block_count), .block_size(block_size), .rd_update(rd_update),
    .wr_update(wr_update), .done_set(done_set), .irq(irq)
  );

  // Reference model: the register map as plain arrays
  logic [31:0]       m_src [NUM_CH];
  logic [31:0]       m_dst [NUM_CH];
  int unsigned       m_cnt [NUM_CH];
  int unsigned       m_bs  [NUM_CH];
  bit                m_en  [NUM_CH];
  bit                m_start [NUM_CH];
  logic [NUM_CH-1:0] m_st, m_ie;
  bit                m_irq;
  logic [31:0]       m_hrdata;
  int                m_err;      // 0 OKAY, 1 first error cycle, 2 second error cycle
  bit                m_dp_wr;
  logic [7:0]        m_dp_addr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_cnt[c] = 0; m_bs[c] = 0;
      m_en[c] = 0; m_start[c] = 0;
    end
    m_st = '0; m_ie = '0; m_irq = 0; m_hrdata = '0; m_err = 0;
    m_dp_wr = 0; m_dp_addr = '0;
  endtask

  function automatic bit m_legal(input logic [7:0] a, input logic [2:0] sz);
    if (sz != 3'b010 || a[1:0] != 2'b00) return 0;
    if (a[7]) return a[6:3] == 4'd0;
    return int'(a[6:4]) < NUM_CH;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int c;
    if (a[7]) return a[2] ? 32'(m_ie) : 32'(m_st);
    c = int'(a[6:4]);
    case (a[3:2])
      2'd0:    return m_en[c] ? 32'h2 : 32'h0;
      2'd1:    return m_src[c];
      2'd2:    return m_dst[c];
      default: return 32'((m_bs[c] << 16) | m_cnt[c]);
    endcase
  endfunction

  // Advance the model by one clock using the inputs present before the edge
  task automatic model_step();
    bit acc, leg, irq_next, wsel;
    int r;
    acc = hsel && hready_in && htrans[1];
    leg = m_legal(haddr, hsize);
    irq_next = |(m_st & m_ie);
    for (int c = 0; c < NUM_CH; c++) begin
      wsel = m_dp_wr && !m_dp_addr[7] && (int'(m_dp_addr[6:4]) == c);
      r = int'(m_dp_addr[3:2]);
      m_start[c] = wsel && r == 0 && hwdata[0];
      if (wsel && r == 0) m_en[c] = hwdata[1];
      if (wsel && r == 1) m_src[c] = hwdata;
      else if (rd_update[c]) m_src[c] = m_src[c] + 32'(m_bs[c] * 4);
      if (wsel && r == 2) m_dst[c] = hwdata;
      else if (wr_update[c]) m_dst[c] = m_dst[c] + 32'(m_bs[c] * 4);
      if (wsel && r == 3) begin
        m_cnt[c] = 32'(hwdata[CNT_W-1:0]);
        m_bs[c]  = 32'(hwdata[16 +: BS_W]);
      end else if (rd_update[c] && m_cnt[c] > 0) begin
        m_cnt[c] = m_cnt[c] - 1;
      end
    end
    if (m_dp_wr && m_dp_addr == 8'h80) m_st = m_st & ~hwdata[NUM_CH-1:0];
    if (m_dp_wr && m_dp_addr == 8'h84) m_ie = hwdata[NUM_CH-1:0];
    m_st = m_st | done_set;
    m_irq = irq_next;
    case (m_err)
      0:       m_err = (acc && !leg) ? 1 : 0;
      1:       m_err = 2;
      default: m_err = (acc && !leg) ? 1 : 0;
    endcase
    m_hrdata  = (acc && leg && !hwrite) ? m_read(haddr) : 32'h0;
    m_dp_wr   = acc && leg && hwrite;
    m_dp_addr = haddr;
  endtask

  task automatic check_all();
    logic [NUM_CH*32-1:0]    e_src, e_dst;
    logic [NUM_CH*CNT_W-1:0] e_cnt;
    logic [NUM_CH*BS_W-1:0]  e_bs;
    logic [NUM_CH-1:0]       e_start, e_en;
    for (int c = 0; c < NUM_CH; c++) begin
      e_src[32*c +: 32]      = m_src[c];
      e_dst[32*c +: 32]      = m_dst[c];
      e_cnt[CNT_W*c +: CNT_W] = CNT_W'(m_cnt[c]);
      e_bs[BS_W*c +: BS_W]    = BS_W'(m_bs[c]);
      e_start[c] = m_start[c];
      e_en[c]    = m_en[c];
    end
    chk_val("hrdata", hrdata, m_hrdata);
    chk_val("hready_out", hready_out, (m_err != 1));
    chk_val("hresp", hresp, (m_err != 0) ? 2'b01 : 2'b00);
    chk_val("irq", irq, m_irq);
    chk_val("start", start, e_start);
    chk_val("dma_en", dma_en, e_en);
    chk_val("src_addr", src_addr, e_src);
    chk_val("dst_addr", dst_addr, e_dst);
    chk_val("block_count", block_count, e_cnt);
    chk_val("block_size", block_size, e_bs);
  endtask

  task automatic tick();
    @(posedge hclk);
    model_step();
    #1;
    check_all();
    hready_in = (m_err != 1);
  endtask

  task automatic idle_inputs();
    hsel = 0; htrans = 2'b00; hwrite = 0; haddr = '0; hsize = 3'b010;
    rd_update = '0; wr_update = '0; done_set = '0;
  endtask

  task automatic addr_phase(input logic [7:0] a, input logic wr);
    hsel = 1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = 3'b010;
    tick();
  endtask

  task automatic data_phase(input logic [31:0] d, input logic [NUM_CH-1:0] rdu,
                            input logic [NUM_CH-1:0] wru, input logic [NUM_CH-1:0] dn);
    hsel = 0; htrans = 2'b00; hwdata = d;
    rd_update = rdu; wr_update = wru; done_set = dn;
    tick();
    rd_update = '0; wr_update = '0; done_set = '0;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    data_phase(d, '0, '0, '0);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    d = hrdata;
    data_phase(32'h0, '0, '0, '0);
  endtask

  initial begin
    logic [31:0] rd;
    int r;
    hreset = 1; hready_in = 1; hwdata = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    chk_val("rst_hready", hready_out, 1'b1);
    chk_val("rst_hresp", hresp, 2'b00);
    check_all();
    hreset = 0;
    tick();

    // Source walk on channel 2 with count saturating at zero
    ahb_write(8'h24, 32'h1000_0000);
    ahb_write(8'h2C, 32'h0004_0003);
    repeat (4) data_phase(32'h0, 4'b0100, '0, '0);
    chk_val("t1_src2", src_addr[95:64], 32'h1000_0040);
    chk_val("t1_cnt2", block_count[47:32], 16'h0);
    ahb_read(8'h2C, rd);
    chk_val("t1_cnt_rd", rd, 32'h0004_0000);

    // CTRL write: one-cycle start, sticky enable
    ahb_write(8'h10, 32'h3);
    chk_val("t2_start_hi", start, 4'b0010);
    chk_val("t2_en", dma_en[1], 1'b1);
    tick();
    chk_val("t2_start_lo", start, 4'b0000);
    ahb_read(8'h10, rd);
    chk_val("t2_ctrl_rd", rd, 32'h2);

    // Illegal channel read: two-cycle ERROR, then a legal read
    addr_phase(8'h50, 1'b0);
    chk_val("t3_err1_rdy", hready_out, 1'b0);
    chk_val("t3_err1_resp", hresp, 2'b01);
    idle_inputs();
    tick();
    chk_val("t3_err2_rdy", hready_out, 1'b1);
    chk_val("t3_err2_resp", hresp, 2'b01);
    addr_phase(8'h24, 1'b0);
    chk_val("t3_ok_resp", hresp, 2'b00);
    chk_val("t3_ok_data", hrdata, 32'h1000_0040);
    data_phase(32'h0, '0, '0, '0);

    // Interrupt: set, irq one cycle later, set beats W1C clear
    ahb_write(8'h84, 32'h1);
    data_phase(32'h0, '0, '0, 4'b0001);
    tick();
    chk_val("t4_irq", irq, 1'b1);
    addr_phase(8'h80, 1'b1);
    data_phase(32'h1, '0, '0, 4'b0001);
    ahb_read(8'h80, rd);
    chk_val("t4_st_kept", rd, 32'h1);
    ahb_write(8'h80, 32'h1);
    ahb_read(8'h80, rd);
    chk_val("t4_st_clr", rd, 32'h0);

    // DST write beats a coincident wr_update
    ahb_write(8'h0C, 32'h0008_0000);
    data_phase(32'h0, '0, 4'b0001, '0);
    chk_val("t5_dst_upd", dst_addr[31:0], 32'h20);
    addr_phase(8'h08, 1'b1);
    data_phase(32'h2000, '0, 4'b0001, '0);
    chk_val("t5_dst_wr", dst_addr[31:0], 32'h2000);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      hsel   = ($urandom_range(0, 3) != 0);
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      r = $urandom_range(0, 15);
      if (r < 10)      haddr = {1'b0, 3'($urandom_range(0, NUM_CH-1)), 2'($urandom), 2'b00};
      else if (r < 12) haddr = {1'b0, 3'($urandom_range(NUM_CH, 7)), 2'($urandom), 2'b00};
      else if (r < 14) haddr = ($urandom_range(0, 1) != 0) ? 8'h84 : 8'h80;
      else             haddr = 8'($urandom);
      hsize     = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
      hwdata    = $urandom;
      rd_update = NUM_CH'($urandom & $urandom);
      wr_update = NUM_CH'($urandom & $urandom);
      done_set  = NUM_CH'($urandom & $urandom & $urandom);
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // Reset asserted during ERR1 with a start pulse live
    addr_phase(8'h00, 1'b1);
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = 8'h50; hsize = 3'b010; hwdata = 32'h1;
    tick();
    chk_val("t6_start", start[0], 1'b1);
    chk_val("t6_err1", hready_out, 1'b0);
    idle_inputs();
    #2 hreset = 1;
    #1;
    chk_val("t6_rdy", hready_out, 1'b1);
    chk_val("t6_resp", hresp, 2'b00);
    chk_val("t6_start_clr", start, 4'b0000);
    chk_val("t6_en", dma_en, 4'b0000);
    chk_val("t6_src", src_addr, '0);
    chk_val("t6_dst", dst_addr, '0);
    chk_val("t6_cnt", {block_size, block_count}, '0);
    chk_val("t6_hrdata", hrdata, 32'h0);
    chk_val("t6_irq", irq, 1'b0);
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    hreset = 0;
    hready_in = 1;
    repeat (2) tick();
    ahb_read(8'h24, rd);
    chk_val("t6_post_rd", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
